dma_mm2s_lite_regs: RTL

- AXI-Lite slave register block: the responder for the DMA read controller's AXI-Lite master port.
- Implements the MM2S control/status register subset (DMACR, DMASR, SA, SA_MSB, LENGTH).
- A LENGTH write launches a transfer request toward the MM2S datapath.
- Completion and error sets IRQ status and drives mm2s_introut back to the controller.
- Used as the MM2S register model in system benches and as the register front-end of the in-house MM2S engine.

---
 rtl/dma_mm2s_lite_regs.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_mm2s_lite_regs.sv
// rtl/dma_mm2s_lite_regs.sv - AXI-Lite MM2S control/status register block
//
// Purpose: AXI-Lite slave holding the MM2S register subset. It holds DMACR, DMASR, SA,
// SA_MSB and LENGTH. A valid LENGTH write launches one transfer toward the datapath.
// Completion and error pulses from the datapath set the IRQ status bits, which drive
// mm2s_introut.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_axi_lite_aw*/w*/b* write address, data and response channels (full-word writes)
//   s_axi_lite_ar*/r*   read address and data channels
//   xfer_start          one-cycle launch pulse; xfer_addr/xfer_len are valid from this cycle
//   xfer_done/xfer_err  one-cycle completion/error pulses from the datapath
//   busy                transfer outstanding
//   mm2s_introut        registered interrupt output
module dma_mm2s_lite_regs #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_lite_awaddr,
  input  logic              s_axi_lite_awvalid,
  output logic              s_axi_lite_awready,
  input  logic [31:0]       s_axi_lite_wdata,
  input  logic              s_axi_lite_wvalid,
  output logic              s_axi_lite_wready,
  output logic [1:0]        s_axi_lite_bresp,
  output logic              s_axi_lite_bvalid,
  input  logic              s_axi_lite_bready,
  input  logic [ADDR_W-1:0] s_axi_lite_araddr,
  input  logic              s_axi_lite_arvalid,
  output logic              s_axi_lite_arready,
  output logic [31:0]       s_axi_lite_rdata,
  output logic [1:0]        s_axi_lite_rresp,
  output logic              s_axi_lite_rvalid,
  input  logic              s_axi_lite_rready,
  output logic              xfer_start,
  output logic [63:0]       xfer_addr,
  output logic [LEN_W-1:0]  xfer_len,
  input  logic              xfer_done,
  input  logic              xfer_err,
  output logic              busy,
  output logic              mm2s_introut
);

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Word indices (byte offset >> 2)
  localparam logic [ADDR_W-3:0] IDX_DMACR  = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] IDX_DMASR  = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] IDX_SA     = (ADDR_W-2)'(6);
  localparam logic [ADDR_W-3:0] IDX_SA_MSB = (ADDR_W-2)'(7);
  localparam logic [ADDR_W-3:0] IDX_LENGTH = (ADDR_W-2)'(10);

  w_state_t          w_state_q, w_state_d;
  r_state_t          r_state_q, r_state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              rs_q, rs_d, ioc_en_q, ioc_en_d, err_en_q, err_en_d;
  logic              ioc_irq_q, ioc_irq_d, err_irq_q, err_irq_d;
  logic [31:0]       sa_q, sa_d, sa_msb_q, sa_msb_d;
  logic [LEN_W-1:0]  len_q, len_d, xfer_len_q, xfer_len_d;
  logic [63:0]       xfer_addr_q, xfer_addr_d;
  logic              busy_q, busy_d, xfer_start_q, xfer_start_d, introut_q, introut_d;
  logic              launch, soft_rst;
  logic [31:0]       rd_val;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{awaddr_q[1:0], s_axi_lite_araddr[1:0]};

  // Ready is gated by rst so it is low during the reset cycle itself.
  assign s_axi_lite_awready = ~rst & (w_state_q == W_IDLE) & ~aw_held_q;
  assign s_axi_lite_wready  = ~rst & (w_state_q == W_IDLE) & ~w_held_q;
  assign s_axi_lite_arready = ~rst & (r_state_q == R_IDLE);
  assign s_axi_lite_bvalid  = (w_state_q == W_RESP);
  assign s_axi_lite_rvalid  = (r_state_q == R_DATA);
  assign s_axi_lite_bresp   = 2'b00;
  assign s_axi_lite_rresp   = 2'b00;
  assign s_axi_lite_rdata   = rdata_q;
  assign xfer_start         = xfer_start_q;
  assign xfer_addr          = xfer_addr_q;
  assign xfer_len           = xfer_len_q;
  assign busy               = busy_q;
  assign mm2s_introut       = introut_q;

  // Write channel FSM: AW and W are captured independently, then one commit cycle.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_lite_awvalid && s_axi_lite_awready) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi_lite_awaddr;
        end
        if (s_axi_lite_wvalid && s_axi_lite_wready) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi_lite_wdata;
        end
        if (aw_held_d && w_held_d) w_state_d = W_COMMIT;
      end
      W_COMMIT: w_state_d = W_RESP;
      W_RESP: begin
        if (s_axi_lite_bready) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read mux reflects register contents in the arvalid handshake cycle.
  always_comb begin
    rd_val = 32'h0;
    case (s_axi_lite_araddr[ADDR_W-1:2])
      IDX_DMACR:  rd_val = {17'b0, err_en_q, 1'b0, ioc_en_q, 11'b0, rs_q};
      IDX_DMASR:  rd_val = {17'b0, err_irq_q, 1'b0, ioc_irq_q, 10'b0,
                            rs_q & ~busy_q, ~rs_q & ~busy_q};
      IDX_SA:     rd_val = sa_q;
      IDX_SA_MSB: rd_val = sa_msb_q;
      IDX_LENGTH: rd_val = {{(32-LEN_W){1'b0}}, len_q};
      default:    rd_val = 32'h0;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_lite_arvalid && s_axi_lite_arready) begin
          r_state_d = R_DATA;
          rdata_d   = rd_val;
        end
      end
      R_DATA:  if (s_axi_lite_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Register update. Priority, lowest first: bus write, datapath events, soft reset.
  always_comb begin
    rs_d         = rs_q;
    ioc_en_d     = ioc_en_q;
    err_en_d     = err_en_q;
    ioc_irq_d    = ioc_irq_q;
    err_irq_d    = err_irq_q;
    sa_d         = sa_q;
    sa_msb_d     = sa_msb_q;
    len_d        = len_q;
    xfer_addr_d  = xfer_addr_q;
    xfer_len_d   = xfer_len_q;
    busy_d       = busy_q;
    xfer_start_d = 1'b0;
    launch       = 1'b0;
    soft_rst     = 1'b0;
    if (w_state_q == W_COMMIT) begin
      case (awaddr_q[ADDR_W-1:2])
        IDX_DMACR: begin
          rs_d     = wdata_q[0];
          ioc_en_d = wdata_q[12];
          err_en_d = wdata_q[14];
          soft_rst = wdata_q[2];
        end
        IDX_DMASR: begin
          if (wdata_q[12]) ioc_irq_d = 1'b0;
          if (wdata_q[14]) err_irq_d = 1'b0;
        end
        IDX_SA:     sa_d = wdata_q;
        IDX_SA_MSB: sa_msb_d = wdata_q;
        IDX_LENGTH: launch = (wdata_q[LEN_W-1:0] != '0) && rs_q && !busy_q;
        default: ;
      endcase
    end
    if (launch) begin
      len_d        = wdata_q[LEN_W-1:0];
      xfer_len_d   = wdata_q[LEN_W-1:0];
      xfer_addr_d  = {sa_msb_q, sa_q};
      busy_d       = 1'b1;
      xfer_start_d = 1'b1;
    end
    // Events override a same-cycle W1C; error wins over done and halts the channel.
    if (busy_q && xfer_err) begin
      busy_d    = 1'b0;
      err_irq_d = 1'b1;
      rs_d      = 1'b0;
    end else if (busy_q && xfer_done) begin
      busy_d    = 1'b0;
      ioc_irq_d = 1'b1;
    end
    introut_d = (ioc_irq_q & ioc_en_q) | (err_irq_q & err_en_q);
    if (soft_rst) begin
      rs_d         = 1'b0;
      ioc_en_d     = 1'b0;
      err_en_d     = 1'b0;
      ioc_irq_d    = 1'b0;
      err_irq_d    = 1'b0;
      sa_d         = 32'h0;
      sa_msb_d     = 32'h0;
      len_d        = '0;
      xfer_addr_d  = 64'h0;
      xfer_len_d   = '0;
      busy_d       = 1'b0;
      xfer_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      rs_q         <= 1'b0;
      ioc_en_q     <= 1'b0;
      err_en_q     <= 1'b0;
      ioc_irq_q    <= 1'b0;
      err_irq_q    <= 1'b0;
      sa_q         <= 32'h0;
      sa_msb_q     <= 32'h0;
      len_q        <= '0;
      xfer_addr_q  <= 64'h0;
      xfer_len_q   <= '0;
      busy_q       <= 1'b0;
      xfer_start_q <= 1'b0;
      introut_q    <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rs_q         <= rs_d;
      ioc_en_q     <= ioc_en_d;
      err_en_q     <= err_en_d;
      ioc_irq_q    <= ioc_irq_d;
      err_irq_q    <= err_irq_d;
      sa_q         <= sa_d;
      sa_msb_q     <= sa_msb_d;
      len_q        <= len_d;
      xfer_addr_q  <= xfer_addr_d;
      xfer_len_q   <= xfer_len_d;
      busy_q       <= busy_d;
      xfer_start_q <= xfer_start_d;
      introut_q    <= introut_d;
    end
  end

endmodule
